regfile_wb_stage: RTL
=====================

# regfile_wb_stage

Write-back stage latch plus 32 x 32-bit MIPS register file. Consumes the 5-bit destination address from the RegDst address mux together with write data and RegWrite. Holds the write in a one-entry write-back register, then commits it to the array. Provides two combinational read ports to decode, with bypass from the pending write-back entry so decode never reads a stale value.

## Interface
Parameters
- DATA_W, 32, register width
- ADDR_W, 5, register address width (32 registers)

Ports
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- WriteAddr  input  ADDR_W  destination register from RegDst address mux
- WriteData  input  DATA_W  result from MemtoReg data mux
- RegWrite  input  1  write request for the current instruction
- Stall  input  1  hold write-back entry, suppress commit
- Flush  input  1  discard write-back entry and incoming write
- ReadAddr1  input  ADDR_W  rs read address
- ReadAddr2  input  ADDR_W  rt read address
- ReadData1  output  DATA_W  rs data, combinational
- ReadData2  output  DATA_W  rt data, combinational
- WbAddr  output  ADDR_W  destination held in write-back entry (for hazard unit)
- WbValid  output  1  write-back entry holds a pending write

## Operation
- State:
  - array R[0..31]
  - write-back entry {WbValid, WbAddr, WbData}
- Capture: an incoming write is qualified as RegWrite && WriteAddr != 0. Writes to $0 are dropped at capture and never set WbValid.
- Commit: on an edge where WbValid=1, Stall=0 and Flush=0, R[WbAddr] <= WbData.
- Entry update on each rising edge, in priority order:
  - Flush=1: WbValid <= 0. No commit this edge. WbAddr/WbData are don't-care but are cleared to 0.
  - Else Stall=1: entry holds. No commit. Incoming write is ignored; upstream is required to hold it.
  - Else: commit the current entry, then load the entry with the qualified incoming write. WbValid <= qualified RegWrite.
- Read path, per port, in priority order:
  - addr == 0 -> 0
  - WbValid && WbAddr == addr -> WbData
  - otherwise -> R[addr]
- Commit and load happen on the same edge. After that edge, a read of the old address returns the array value; a read of the new address returns the bypassed value.
- R[0] is never written and always reads 0.

## Timing
- Reset (reset_n=0, asynchronous): all R[i]=0, WbValid=0, WbAddr=0, WbData=0. Hence ReadData1/2=0 and WbValid=0 immediately, with no clock required.
- Reset asserted mid-operation: any pending write is lost. No partial commit.
- Release: the first capture occurs on the first rising edge with reset_n=1.
- Write latency:
  - Write presented before edge k becomes visible on read ports (bypass) after edge k.
  - The array is updated at edge k+1 (or at the first later edge with Stall=0 and Flush=0).
- Read latency: zero cycles, combinational from ReadAddr, entry and array.
- Back-to-back writes to the same register: the entry always holds the youngest value. The array receives the older value at the same edge the entry loads the younger one. No write is lost.
- Stall and Flush asserted together: Flush wins.
- Stall held N cycles: the entry and bypass stay constant for N cycles, and the array is unchanged.
- No X propagation: outputs are defined for all inputs after reset.

## Test plan
- Reset: write R5=0x1234 and let it commit, then pulse reset_n low mid-cycle -> ReadData1 (addr 5) = 0 and WbValid = 0 asynchronously, before the next edge.
- Write/bypass/commit: RegWrite=1, WriteAddr=8, WriteData=0xDEADBEEF at edge 1 -> after edge 1, WbValid=1, WbAddr=8, ReadData1 (addr 8) = 0xDEADBEEF. Then RegWrite=0 at edge 2 -> WbValid=0, read of 8 still returns 0xDEADBEEF from the array.
- $0 protection: RegWrite=1, WriteAddr=0, WriteData=0xFFFFFFFF -> WbValid stays 0, ReadData2 (addr 0) = 0 at every cycle.
- Back-to-back same address: writes to R3 of 0x1, then 0x2, then 0x3 on consecutive edges -> read of 3 shows 1, 2, 3 after each edge, and after a further idle edge R3 = 0x3.
- Stall: pending entry R9=0xA5A5A5A5 with Stall=1 for 3 edges, and an incoming write of R10 offered -> read of 9 = 0xA5A5A5A5 via bypass, R10 remains 0. After Stall drops, R9 commits at that edge.
- Flush priority: pending R12=0x77, then Stall=1 and Flush=1 on the same edge -> WbValid=0, read of 12 = 0 (the old array value), and R12 is never written.

Source files
------------

// File: rtl/regfile_wb_stage.sv
// Write-back entry plus 32 x 32-bit register file.
// Two combinational read ports bypass from the pending entry.
module regfile_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [ADDR_W-1:0] ReadAddr1,
    input  logic [ADDR_W-1:0] ReadAddr2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [ADDR_W-1:0] WbAddr,
    output logic              WbValid
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] rf_q [NREG];

    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_addr_q,  wb_addr_d;
    logic [DATA_W-1:0] wb_data_q,  wb_data_d;
    logic              wr_ok;
    logic              commit;

    assign wr_ok  = RegWrite && (WriteAddr != '0);
    assign commit = wb_valid_q && !Stall && !Flush;

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (Flush) begin
            wb_valid_d = 1'b0;
            wb_addr_d  = '0;
            wb_data_d  = '0;
        end else if (!Stall) begin
            wb_valid_d = wr_ok;
            wb_addr_d  = wr_ok ? WriteAddr : '0;
            wb_data_d  = wr_ok ? WriteData : '0;
        end
    end

    // Commit of the old entry and load of the new one share an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            if (commit) begin
                rf_q[wb_addr_q] <= wb_data_q;
            end
        end
    end

    always_comb begin
        if (ReadAddr1 == '0) begin
            ReadData1 = '0;
        end else if (wb_valid_q && wb_addr_q == ReadAddr1) begin
            ReadData1 = wb_data_q;
        end else begin
            ReadData1 = rf_q[ReadAddr1];
        end
    end

    always_comb begin
        if (ReadAddr2 == '0) begin
            ReadData2 = '0;
        end else if (wb_valid_q && wb_addr_q == ReadAddr2) begin
            ReadData2 = wb_data_q;
        end else begin
            ReadData2 = rf_q[ReadAddr2];
        end
    end

    assign WbAddr  = wb_addr_q;
    assign WbValid = wb_valid_q;

endmodule
